// File: rtl/squat_mq_if.sv
// squat_mq_if: receive/transmit cell handshake bundle.
// master drives cells in and sinks cells out; slave is the switch.
interface squat_mq_if #(
  parameter int NumRx = 4,
  parameter int NumTx = 4
);
  logic [NumRx-1:0]     rx_valid;
  logic [NumRx-1:0]     rx_ready;
  logic [NumRx*424-1:0] rx_cell;
  logic [NumTx-1:0]     tx_valid;
  logic [NumTx-1:0]     tx_ready;
  logic [NumTx*424-1:0] tx_cell;

  modport master (
    output rx_valid, rx_cell, tx_ready,
    input  rx_ready, tx_valid, tx_cell
  );

  modport slave (
    input  rx_valid, rx_cell, tx_ready,
    output rx_ready, tx_valid, tx_cell
  );
endinterface

// File: rtl/squat_mq.sv
// squat_mq: ATM UNI->NNI cell switch with VPI translation,
// HEC check and one cell queue per transmit port.
module squat_mq #(
  parameter int NumRx      = 4,
  parameter int NumTx      = 4,
  parameter int QDepth     = 4,
  parameter int DropOnFull = 1,
  parameter int HecCheck   = 1,
  parameter int CntW       = 16
) (
  input  logic              clk,
  input  logic              rst,
  squat_mq_if.slave         bus,
  input  logic              cfg_we,
  input  logic [7:0]        cfg_addr,
  input  logic [NumTx+11:0] cfg_wdata,
  output logic [NumTx+11:0] cfg_rdata,
  output logic [CntW-1:0]   hec_err_cnt,
  output logic [CntW-1:0]   drop_cnt
);
  localparam int PW = (NumRx > 1) ? $clog2(NumRx) : 1;
  localparam int AW = $clog2(QDepth);
  localparam int CW = $clog2(QDepth + 1);

  typedef enum logic [1:0] {ARB, CHECK, ENQ} state_t;

  state_t st, nxt;

  logic [PW-1:0]     rr_ptr;
  logic [PW-1:0]     gidx;
  logic [NumRx-1:0]  gnt;
  logic              hit;
  logic              arb;
  logic [423:0]      cell_q;
  logic [NumTx-1:0]  fwd_q;
  logic [NumTx+11:0] tbl [256];
  logic [NumTx+11:0] ent;
  logic [31:0]       hdr_new;
  logic [7:0]        hec_new;
  logic              hec_bad;
  logic [NumTx-1:0]  push, pop, blk;
  logic              hec_inc, drop_inc;

  logic [423:0]      mem [NumTx][QDepth];
  logic [AW-1:0]     wp [NumTx];
  logic [AW-1:0]     rp [NumTx];
  logic [CW-1:0]     cnt [NumTx];

  function automatic logic [7:0] hec_of(
    input logic [31:0] h
  );
    logic [7:0] c;
    c = 8'h00;
    for (int b = 3; b >= 0; b--) begin
      c = c ^ h[b*8 +: 8];
      for (int k = 0; k < 8; k++) begin
        c = c[7] ? ({c[6:0], 1'b0} ^ 8'h07)
                 : {c[6:0], 1'b0};
      end
    end
    return c ^ 8'h55;
  endfunction

  // first valid port at or after rr_ptr, cyclically
  always_comb begin
    int idx;
    idx  = 0;
    gnt  = '0;
    gidx = '0;
    hit  = 1'b0;
    for (int k = 0; k < NumRx; k++) begin
      idx = (int'(rr_ptr) + k) % NumRx;
      if (!hit && bus.rx_valid[idx]) begin
        hit      = 1'b1;
        gidx     = PW'(idx);
        gnt[idx] = 1'b1;
      end
    end
  end

  assign arb          = (st == ARB) && rst;
  assign bus.rx_ready = arb ? gnt : '0;

  assign ent     = tbl[cell_q[419:412]];
  assign hdr_new = {ent[11:0], cell_q[411:392]};
  assign hec_new = hec_of(hdr_new);
  assign hec_bad = (HecCheck != 0) &&
    (hec_of(cell_q[423:392]) != cell_q[391:384]);

  assign pop = bus.tx_valid & bus.tx_ready;

  // a full queue popped this cycle can still take a push
  always_comb begin
    blk = '0;
    for (int j = 0; j < NumTx; j++) begin
      blk[j] = (cnt[j] == CW'(QDepth)) && !pop[j];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) st <= ARB;
    else      st <= nxt;
  end

  always_comb begin
    nxt      = st;
    push     = '0;
    hec_inc  = 1'b0;
    drop_inc = 1'b0;
    unique case (st)
      ARB: begin
        if (hit) nxt = CHECK;
      end
      CHECK: begin
        hec_inc = hec_bad;
        nxt     = hec_bad ? ARB : ENQ;
      end
      ENQ: begin
        if (fwd_q == '0) begin
          drop_inc = 1'b1;
          nxt      = ARB;
        end else if (DropOnFull != 0) begin
          push     = fwd_q & ~blk;
          drop_inc = |(fwd_q & blk);
          nxt      = ARB;
        end else if (!(|(fwd_q & blk))) begin
          push = fwd_q;
          nxt  = ARB;
        end
      end
      default: nxt = ARB;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rr_ptr <= '0;
      cell_q <= '0;
      fwd_q  <= '0;
    end else begin
      if (st == ARB && hit) begin
        cell_q <= bus.rx_cell[int'(gidx)*424 +: 424];
        rr_ptr <= (int'(gidx) == NumRx - 1) ? '0
                                            : gidx + 1'b1;
      end
      if (st == CHECK && !hec_bad) begin
        cell_q[423:384] <= {hdr_new, hec_new};
        fwd_q           <= ent[NumTx+11:12];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hec_err_cnt <= '0;
      drop_cnt    <= '0;
    end else begin
      if (hec_inc && hec_err_cnt != '1)
        hec_err_cnt <= hec_err_cnt + 1'b1;
      if (drop_inc && drop_cnt != '1)
        drop_cnt <= drop_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 256; i++) tbl[i] <= '0;
      cfg_rdata <= '0;
    end else begin
      if (cfg_we) tbl[cfg_addr] <= cfg_wdata;
      cfg_rdata <= tbl[cfg_addr];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int j = 0; j < NumTx; j++) begin
        wp[j]  <= '0;
        rp[j]  <= '0;
        cnt[j] <= '0;
      end
    end else begin
      for (int j = 0; j < NumTx; j++) begin
        if (push[j]) wp[j] <= wp[j] + 1'b1;
        if (pop[j])  rp[j] <= rp[j] + 1'b1;
        if (push[j] && !pop[j])
          cnt[j] <= cnt[j] + 1'b1;
        else if (!push[j] && pop[j])
          cnt[j] <= cnt[j] - 1'b1;
      end
    end
  end

  // cell storage needs no reset; emptiness lives in cnt
  always_ff @(posedge clk) begin
    for (int j = 0; j < NumTx; j++) begin
      if (push[j]) mem[j][wp[j]] <= cell_q;
    end
  end

  for (genvar j = 0; j < NumTx; j++) begin : g_tx
    assign bus.tx_valid[j] = (cnt[j] != '0);
    assign bus.tx_cell[j*424 +: 424] = mem[j][rp[j]];
  end
endmodule

// File: tb/tb_squat_mq.sv
// tb_squat_mq: directed scoreboard bench for three squat_mq
// variants (defaults, stall-on-full, HEC check off).
module tb_squat_mq;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic        cfg_we;
  logic [7:0]  cfg_addr;
  logic [15:0] cfg_wdata;
  logic [15:0] rd_a, rd_b, rd_c;
  logic [15:0] hec_a, drop_a, hec_c, drop_c;
  logic [1:0]  hec_b, drop_b;

  squat_mq_if ifa ();
  squat_mq_if ifb ();
  squat_mq_if ifc ();

  squat_mq u_a (
    .clk(clk), .rst(rst), .bus(ifa),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr),
    .cfg_wdata(cfg_wdata), .cfg_rdata(rd_a),
    .hec_err_cnt(hec_a), .drop_cnt(drop_a)
  );

  squat_mq #(.DropOnFull(0), .CntW(2)) u_b (
    .clk(clk), .rst(rst), .bus(ifb),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr),
    .cfg_wdata(cfg_wdata), .cfg_rdata(rd_b),
    .hec_err_cnt(hec_b), .drop_cnt(drop_b)
  );

  squat_mq #(.HecCheck(0)) u_c (
    .clk(clk), .rst(rst), .bus(ifc),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr),
    .cfg_wdata(cfg_wdata), .cfg_rdata(rd_c),
    .hec_err_cnt(hec_c), .drop_cnt(drop_c)
  );

  typedef struct {
    int           d;
    int           p;
    logic [423:0] c;
  } exp_t;

  typedef struct {
    int p;
    bit gap;
  } g_t;

  exp_t exp_q [$];
  g_t   exp_g [$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   last_g = 0;
  bit   gchk = 1'b0;

  always @(posedge clk) cyc++;

  task automatic chk(input string nm,
                     input logic [63:0] got,
                     input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %0h want %0h", nm, got, want);
    end
  endtask

  function automatic logic [7:0] hec(input logic [31:0] h);
    logic [7:0] r;
    logic       fb;
    r = 8'h00;
    for (int i = 31; i >= 0; i--) begin
      fb = r[7] ^ h[i];
      r  = {r[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
    end
    return r ^ 8'h55;
  endfunction

  function automatic logic [423:0] mkcell(
    input logic [31:0] h, input logic [7:0] hv,
    input logic [7:0] s);
    logic [423:0] c;
    c[423:392] = h;
    c[391:384] = hv;
    for (int i = 0; i < 48; i++) c[i*8 +: 8] = s + 8'(i);
    return c;
  endfunction

  function automatic logic [423:0] good(
    input logic [31:0] h, input logic [7:0] s);
    return mkcell(h, hec(h), s);
  endfunction

  task automatic expect_cell(input int d, input int p,
                             input logic [423:0] c);
    exp_t e;
    e.d = d;
    e.p = p;
    e.c = c;
    exp_q.push_back(e);
  endtask

  task automatic mon(input int d, input logic [3:0] v,
                     input logic [3:0] r,
                     input logic [1695:0] cells);
    int k;
    for (int j = 0; j < 4; j++) begin
      if (v[j] && r[j]) begin
        k = -1;
        for (int i = 0; i < exp_q.size(); i++)
          if (k < 0 && exp_q[i].d == d && exp_q[i].p == j)
            k = i;
        checks++;
        if (k < 0) begin
          errors++;
          $display("FAIL tx dut%0d port%0d got %h want none",
                   d, j, cells[j*424 +: 424]);
        end else begin
          if (cells[j*424 +: 424] !== exp_q[k].c) begin
            errors++;
            $display("FAIL tx dut%0d port%0d got %h want %h",
                     d, j, cells[j*424 +: 424], exp_q[k].c);
          end
          exp_q.delete(k);
        end
      end
    end
  endtask

  always @(negedge clk) begin
    logic [3:0] hs;
    int         gi;
    g_t         g;
    mon(0, ifa.tx_valid, ifa.tx_ready, ifa.tx_cell);
    mon(1, ifb.tx_valid, ifb.tx_ready, ifb.tx_cell);
    mon(2, ifc.tx_valid, ifc.tx_ready, ifc.tx_cell);
    hs = ifa.rx_valid & ifa.rx_ready;
    if (gchk && hs != 4'b0) begin
      gi = -1;
      for (int i = 3; i >= 0; i--) if (hs[i]) gi = i;
      checks++;
      if (exp_g.size() == 0) begin
        errors++;
        $display("FAIL grant got %0d want none", gi);
      end else begin
        g = exp_g.pop_front();
        if (gi != g.p || !$onehot(ifa.rx_ready) ||
            (g.gap && cyc - last_g != 3)) begin
          errors++;
          $display("FAIL grant got port %0d gap %0d want port %0d gap 3",
                   gi, cyc - last_g, g.p);
        end
      end
      last_g = cyc;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_rx(input int d, input int p, input bit v,
                        input logic [423:0] c);
    case (d)
      0: begin
        ifa.rx_valid[p] = v;
        ifa.rx_cell[p*424 +: 424] = c;
      end
      1: begin
        ifb.rx_valid[p] = v;
        ifb.rx_cell[p*424 +: 424] = c;
      end
      default: begin
        ifc.rx_valid[p] = v;
        ifc.rx_cell[p*424 +: 424] = c;
      end
    endcase
  endtask

  function automatic bit rdy(input int d, input int p);
    case (d)
      0:       return ifa.rx_ready[p];
      1:       return ifb.rx_ready[p];
      default: return ifc.rx_ready[p];
    endcase
  endfunction

  // returns one step into the CHECK cycle after the handshake
  task automatic send(input int d, input int p,
                      input logic [423:0] c);
    int n;
    set_rx(d, p, 1'b1, c);
    #1;
    n = 0;
    while (!rdy(d, p) && n < 50) begin
      tick(1);
      n++;
    end
    chk("grant timeout", 64'(n < 50), 64'd1);
    tick(1);
    set_rx(d, p, 1'b0, c);
  endtask

  task automatic cfgw(input logic [7:0] a,
                      input logic [15:0] w);
    cfg_we    = 1'b1;
    cfg_addr  = a;
    cfg_wdata = w;
    tick(1);
    cfg_we = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 300) begin
      tick(1);
      n++;
    end
    chk("scoreboard drain", 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [423:0] c;
    logic [3:0]   hs;
    int           n, g;

    cfg_we = 1'b0; cfg_addr = '0; cfg_wdata = '0;
    ifa.rx_valid = '0; ifa.rx_cell = '0; ifa.tx_ready = 4'hF;
    ifb.rx_valid = '0; ifb.rx_cell = '0; ifb.tx_ready = 4'h0;
    ifc.rx_valid = '0; ifc.rx_cell = '0; ifc.tx_ready = 4'hF;

    // reset state
    tick(2);
    chk("rst tx_valid", 64'(ifa.tx_valid), 64'h0);
    chk("rst rx_ready", 64'(ifa.rx_ready), 64'h0);
    chk("rst hec_cnt", 64'(hec_a), 64'h0);
    chk("rst drop_cnt", 64'(drop_a), 64'h0);
    chk("rst cfg_rdata", 64'(rd_a), 64'h0);
    rst = 1'b1;
    tick(1);

    cfgw(8'd5, {4'b0001, 12'h0AB});
    cfgw(8'd1, {4'b1111, 12'h123});
    cfgw(8'd0, {4'b0010, 12'h00F});
    cfg_addr = 8'd5;
    tick(1);
    chk("cfg readback", 64'(rd_a), 64'h10AB);

    // round-robin over four continuously valid ports
    exp_g.push_back('{0, 1'b0});
    exp_g.push_back('{1, 1'b1});
    exp_g.push_back('{2, 1'b1});
    exp_g.push_back('{3, 1'b1});
    exp_g.push_back('{0, 1'b1});
    for (int k = 0; k < 5; k++) begin
      int p;
      p = k % 4;
      expect_cell(0, 0, good(32'h0AB00000 | (p + 1), 8'h10));
    end
    gchk = 1'b1;
    for (int p = 0; p < 4; p++)
      set_rx(0, p, 1'b1, good(32'h00500000 | (p + 1), 8'h10));
    #1;
    n = 0;
    g = 0;
    while (g < 5 && n < 100) begin
      hs = ifa.rx_valid & ifa.rx_ready;
      if (hs != 4'b0) g++;
      tick(1);
      n++;
    end
    ifa.rx_valid = '0;
    chk("rr burst timeout", 64'(g), 64'd5);
    tick(1);
    gchk = 1'b0;
    drain();

    // single cell: translation and latency
    expect_cell(0, 0, good(32'h0AB00010, 8'h20));
    send(0, 0, good(32'h00500010, 8'h20));
    tick(1);
    chk("latency T+2", 64'(ifa.tx_valid), 64'h0);
    tick(1);
    chk("latency T+3", 64'(ifa.tx_valid), 64'h1);
    drain();

    // bad HEC: dropped by a, forwarded by c
    c = mkcell(32'h00000001, 8'h53, 8'h30);
    send(0, 2, c);
    expect_cell(2, 1, good(32'h00F00001, 8'h30));
    send(2, 2, c);
    tick(3);
    chk("hec_err_cnt", 64'(hec_a), 64'd1);
    chk("hec drop tx", 64'(ifa.tx_valid), 64'h0);
    drain();

    // entry with no forward bits
    send(0, 3, good(32'h00200000, 8'h40));
    tick(3);
    chk("fwd0 drop_cnt", 64'(drop_a), 64'd1);

    // overflow with DropOnFull=1
    ifa.tx_ready = 4'h0;
    for (int i = 0; i < 5; i++) begin
      if (i < 4)
        for (int j = 0; j < 4; j++)
          expect_cell(0, j, good(32'h12300000 | i, 8'h50));
      send(0, 0, good(32'h00100000 | i, 8'h50));
    end
    tick(4);
    chk("full drop_cnt", 64'(drop_a), 64'd2);
    chk("full tx_valid", 64'(ifa.tx_valid), 64'hF);
    ifa.tx_ready = 4'hF;
    drain();

    // overflow with DropOnFull=0: hold in ENQ
    for (int i = 0; i < 6; i++)
      for (int j = 0; j < 4; j++)
        expect_cell(1, j, good(32'h12300000 | i, 8'h60));
    for (int i = 0; i < 5; i++)
      send(1, 0, good(32'h00100000 | i, 8'h60));
    tick(2);
    set_rx(1, 1, 1'b1, good(32'h00100005, 8'h60));
    for (int k = 0; k < 6; k++) begin
      tick(1);
      chk("stall rx_ready", 64'(ifb.rx_ready), 64'h0);
    end
    ifb.tx_ready = 4'hF;
    tick(1);
    ifb.tx_ready = 4'h0;
    send(1, 1, good(32'h00100005, 8'h60));
    tick(4);
    chk("stall tx_valid", 64'(ifb.tx_valid), 64'hF);
    chk("stall drop_cnt", 64'(drop_b), 64'd0);
    ifb.tx_ready = 4'hF;
    drain();

    // table write racing a lookup of the same VPI
    expect_cell(0, 0, good(32'h0AB00077, 8'h70));
    send(0, 0, good(32'h00500077, 8'h70));
    cfgw(8'd5, {4'b0010, 12'h0CD});
    expect_cell(0, 1, good(32'h0CD00078, 8'h71));
    send(0, 0, good(32'h00500078, 8'h71));
    drain();

    // reset during ENQ
    ifa.tx_ready = 4'h0;
    send(0, 0, good(32'h00100099, 8'h80));
    tick(1);
    rst = 1'b0;
    #1;
    chk("mid rst tx_valid", 64'(ifa.tx_valid), 64'h0);
    chk("mid rst hec_cnt", 64'(hec_a), 64'h0);
    chk("mid rst drop_cnt", 64'(drop_a), 64'h0);
    chk("mid rst cfg_rdata", 64'(rd_a), 64'h0);
    for (int p = 0; p < 4; p++)
      set_rx(0, p, 1'b1, good(32'h00300000, 8'h90));
    #1;
    chk("mid rst rx_ready", 64'(ifa.rx_ready), 64'h0);
    tick(2);
    gchk = 1'b1;
    exp_g.push_back('{0, 1'b0});
    rst = 1'b1;
    #1;
    n = 0;
    while ((ifa.rx_valid & ifa.rx_ready) == 4'b0 && n < 20) begin
      tick(1);
      n++;
    end
    chk("post rst grant timeout", 64'(n < 20), 64'd1);
    tick(1);
    ifa.rx_valid = '0;
    gchk = 1'b0;
    chk("post rst grant seen", 64'(exp_g.size()), 64'd0);
    ifa.tx_ready = 4'hF;

    // counter saturation on the 2-bit variant
    for (int i = 0; i < 4; i++)
      send(1, 2, good(32'h00300000 | i, 8'hA0));
    tick(3);
    chk("drop saturate", 64'(drop_b), 64'd3);

    drain();
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end
endmodule

// File: doc/squat_mq.md
SQUAT_MQ -- requirements
Module: squat_mq

Interface
REQ-001 SHALL have parameter NumRx, default 4, meaning receive port count (1..16).
REQ-002 SHALL have parameter NumTx, default 4, meaning transmit port count (1..16).
REQ-003 SHALL have parameter QDepth, default 4, meaning cells per Tx queue (power of 2, >=2).
REQ-004 SHALL have parameter DropOnFull, default 1, meaning 1 = drop to full queues, 0 = stall until all targets have space.
REQ-005 SHALL have parameter HecCheck, default 1, meaning 1 = discard bad-HEC cells, 0 = skip the check.
REQ-006 SHALL have parameter CntW, default 16, meaning error counter width.
REQ-007 SHALL have port clk, input, 1 bit, the single clock; all logic on rising edge.
REQ-008 SHALL have port rst, input, 1 bit, reset; asynchronous, active-low.
REQ-009 SHALL have port rx_valid, input, NumRx bits: a cell is offered on port i.
REQ-010 SHALL have port rx_ready, output, NumRx bits: port i is granted; the cell transfers when valid and ready are both high.
REQ-011 SHALL have port rx_cell, input, NumRx*424 bits: 53-byte UNI cell per port, byte 0 in the MSBs.
REQ-012 SHALL have port tx_valid, output, NumTx bits: queue j is non-empty.
REQ-013 SHALL have port tx_ready, input, NumTx bits: sink j accepts the head cell.
REQ-014 SHALL have port tx_cell, output, NumTx*424 bits: NNI cell at the head of queue j.
REQ-015 SHALL have ports cfg_we (in, 1), cfg_addr (in, 8) and cfg_wdata (in, NumTx+12): the lookup-table write port.
REQ-016 SHALL have port cfg_rdata, out, NumTx+12 bits: entry at cfg_addr, registered, valid 1 cycle after cfg_addr.
REQ-017 SHALL have ports hec_err_cnt and drop_cnt, out, CntW bits each: the error counters.

Function
REQ-018 SHALL hold a 256-entry table indexed by UNI VPI (byte0[3:0],byte1[7:4]); each entry is {forward[NumTx-1:0], new_vpi[11:0]}; forward bit j selects Tx j.
REQ-019 SHALL run FSM ARB -> CHECK -> ENQ -> ARB; one cell per 3 cycles maximum.
REQ-020 SHALL, in ARB, assert rx_ready only for the granted port: the first valid port at or after rr_ptr, cyclically; rx_ready SHALL be all 0 in every other state.
REQ-021 SHALL, on transfer from port g, capture the cell, set rr_ptr to (g+1) mod NumRx and go to CHECK; with no valid port, SHALL stay in ARB with rr_ptr unchanged.
REQ-022 SHALL compute HEC as CRC-8 (poly 0x07, init 0x00) over header bytes 0-3, XORed with 0x55.
REQ-023 SHALL, in CHECK with HecCheck=1 and HEC mismatch, increment hec_err_cnt and return to ARB.
REQ-024 SHALL otherwise, in CHECK, read the entry, replace GFC+VPI with new_vpi, recompute byte 4 over the new header, and go to ENQ.
REQ-025 SHALL, in ENQ with forward==0, increment drop_cnt once and return to ARB.
REQ-026 SHALL, in ENQ with DropOnFull=1, push the cell into every non-full selected queue in one cycle, increment drop_cnt once if any selected queue was full, and return to ARB.
REQ-027 SHALL, in ENQ with DropOnFull=0, stay in ENQ while any selected queue is full, then push to all selected queues in one cycle.
REQ-028 SHALL pop queue j when tx_valid[j] and tx_ready[j]; push and pop in the same cycle on a full queue SHALL both occur and the queue SHALL stay full.
REQ-029 SHALL keep per-queue read/write pointers that wrap modulo QDepth, plus a count in 0..QDepth.
REQ-030 SHALL have tx_valid rise at the 3rd clk after the accepting edge (accept T, CHECK T+1, ENQ T+2, tx_valid T+3) when the queue was empty.
REQ-031 SHALL apply a cfg write at the clock edge; a lookup in the same cycle SHALL see the old entry.
REQ-032 SHALL saturate both counters at all-ones; they SHALL never wrap.

Reset
REQ-033 SHALL, while rst=0, force state ARB, rr_ptr=0, all queues empty, tx_valid=0, rx_ready=0, counters=0, all table entries=0, cfg_rdata=0.
REQ-034 SHALL discard any in-flight cell when reset asserts mid-operation; the first grant after release SHALL evaluate port 0 first.

Verification
REQ-035 Table[5]={0001,0x0AB}; Rx0 header 00 50 00 10 + good HEC -> Tx0 at T+3 with header 0A B0 00 10, recomputed HEC; other tx_valid=0.
REQ-036 All 4 Rx valid continuously -> grants 0,1,2,3,0, one every 3 cycles.
REQ-037 Header 00 00 00 01, HEC 0x53 (expected 0x52) -> no tx_valid, hec_err_cnt=1; with HecCheck=0 the cell is forwarded.
REQ-038 forward=1111, tx_ready=0, QDepth=4 -> 5th cell with DropOnFull=1: drop_cnt=1, queues hold 4; with DropOnFull=0: FSM holds ENQ until one pop frees all 4 queues.
REQ-039 cfg_we at address 5 in the same cycle as a CHECK lookup of VPI 5 -> old entry used; the next cell uses the new entry.
REQ-040 rst low during ENQ -> all outputs at reset values; rx_valid=1111 after release -> port 0 granted first.
